// File: rtl/xdma_meta_manager_mq_if.sv
// Bundle for the metadata queue of the XDMA write path.
// Ports: metadata handshake (meta_valid_i/meta_ready_o/meta_id_i/meta_len_i),
//        beat accounting (write_happening_i/write_ready_o, cur_*, beat_cnt_o),
//        completion handshake (done_valid_o/done_id_o/done_ready_i),
//        flush_i, occupancy_o and err_zero_len_o.
// Signal suffixes are from the manager's point of view; the slave modport is
// the manager, the master modport is the surrounding DMA engine.
interface xdma_meta_manager_mq_if #(
  parameter int unsigned IdWidth  = 8,
  parameter int unsigned LenWidth = 16,
  parameter int unsigned Depth    = 4
);
  localparam int unsigned OccWidth = $clog2(Depth) + 1;

  logic                meta_valid_i;
  logic                meta_ready_o;
  logic [IdWidth-1:0]  meta_id_i;
  logic [LenWidth-1:0] meta_len_i;
  logic                write_happening_i;
  logic                write_ready_o;
  logic                cur_valid_o;
  logic [IdWidth-1:0]  cur_dma_id_o;
  logic [LenWidth-1:0] beat_cnt_o;
  logic                done_valid_o;
  logic [IdWidth-1:0]  done_id_o;
  logic                done_ready_i;
  logic                flush_i;
  logic [OccWidth-1:0] occupancy_o;
  logic                err_zero_len_o;

  modport slave (
    input  meta_valid_i, meta_id_i, meta_len_i, write_happening_i,
           done_ready_i, flush_i,
    output meta_ready_o, write_ready_o, cur_valid_o, cur_dma_id_o,
           beat_cnt_o, done_valid_o, done_id_o, occupancy_o, err_zero_len_o
  );

  modport master (
    output meta_valid_i, meta_id_i, meta_len_i, write_happening_i,
           done_ready_i, flush_i,
    input  meta_ready_o, write_ready_o, cur_valid_o, cur_dma_id_o,
           beat_cnt_o, done_valid_o, done_id_o, occupancy_o, err_zero_len_o
  );
endinterface

// File: rtl/xdma_meta_manager_mq.sv
// Metadata queue manager for the XDMA write path.
// Holds up to Depth outstanding requests (ID, length in beats), counts write
// beats against the head request, and emits a completion record with the
// head ID once its last beat is counted.
// Ports:
//   clk_i  - sole clock, rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - xdma_meta_manager_mq_if.slave: metadata in, beat accounting,
//            completion out, flush, occupancy and zero-length error pulse
module xdma_meta_manager_mq #(
  parameter int unsigned IdWidth  = 8,
  parameter int unsigned LenWidth = 16,
  parameter int unsigned Depth    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  xdma_meta_manager_mq_if.slave bus
);

  localparam int unsigned PtrWidth = $clog2(Depth);
  localparam int unsigned OccWidth = PtrWidth + 1;
  localparam int unsigned CntWidth = LenWidth + 1;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  state_e              state_q,    state_n;
  logic [PtrWidth-1:0] rd_ptr_q,   rd_ptr_n;
  logic [PtrWidth-1:0] wr_ptr_q,   wr_ptr_n;
  logic [OccWidth-1:0] occ_q,      occ_n;
  logic [IdWidth-1:0]  head_id_q,  head_id_n;
  logic [LenWidth-1:0] head_len_q, head_len_n;
  logic [LenWidth-1:0] beat_cnt_q, beat_cnt_n;
  logic                cur_valid_q;
  logic                done_valid_q, done_valid_n;
  logic [IdWidth-1:0]  done_id_q,    done_id_n;
  logic                err_q;

  logic [IdWidth-1:0]  mem_id  [Depth];
  logic [LenWidth-1:0] mem_len [Depth];

  logic                meta_ready;
  logic                write_ready;
  logic                accept;
  logic                enq;
  logic                zero_drop;
  logic                beat;
  logic                last_beat;
  logic                pop;
  logic [OccWidth-1:0] remaining;

  // Handshake qualifiers; flush blocks both enqueue and beat counting.
  assign meta_ready  = (occ_q < OccWidth'(Depth)) && !bus.flush_i;
  assign write_ready = cur_valid_q && !(done_valid_q && !bus.done_ready_i);
  assign accept      = bus.meta_valid_i && meta_ready;
  assign enq         = accept && (bus.meta_len_i != '0);
  assign zero_drop   = accept && (bus.meta_len_i == '0);
  assign beat        = bus.write_happening_i && write_ready && !bus.flush_i;
  // One extra bit keeps the compare exact even for a full-range length.
  assign last_beat   = ({1'b0, beat_cnt_q} + CntWidth'(1)) == {1'b0, head_len_q};
  assign pop         = beat && last_beat;

  // Next-state for pointers, occupancy, head cache, beat counter, completion.
  always_comb begin
    rd_ptr_n     = rd_ptr_q;
    wr_ptr_n     = wr_ptr_q;
    occ_n        = occ_q;
    head_id_n    = head_id_q;
    head_len_n   = head_len_q;
    beat_cnt_n   = beat_cnt_q;
    done_valid_n = done_valid_q;
    done_id_n    = done_id_q;
    remaining    = occ_q - OccWidth'(pop);

    if (bus.flush_i) begin
      rd_ptr_n   = '0;
      wr_ptr_n   = '0;
      occ_n      = '0;
      beat_cnt_n = '0;
    end else begin
      if (pop) begin
        rd_ptr_n   = rd_ptr_q + PtrWidth'(1);
        beat_cnt_n = '0;
      end else if (beat) begin
        beat_cnt_n = beat_cnt_q + LenWidth'(1);
      end
      if (enq) begin
        wr_ptr_n = wr_ptr_q + PtrWidth'(1);
      end
      occ_n = occ_q + OccWidth'(enq) - OccWidth'(pop);
    end

    // Head cache: empty -> zeros; entry being written this cycle becomes the
    // head when nothing older survives, otherwise read it from storage.
    if (occ_n == '0) begin
      head_id_n  = '0;
      head_len_n = '0;
    end else if (remaining == '0) begin
      head_id_n  = bus.meta_id_i;
      head_len_n = bus.meta_len_i;
    end else begin
      head_id_n  = mem_id[rd_ptr_n];
      head_len_n = mem_len[rd_ptr_n];
    end

    // A new completion wins over retiring the previous one.
    if (pop) begin
      done_valid_n = 1'b1;
      done_id_n    = head_id_q;
    end else if (done_valid_q && bus.done_ready_i) begin
      done_valid_n = 1'b0;
    end

    state_n = (occ_n != '0) ? ACTIVE : IDLE;
  end

  // Control state and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      occ_q        <= '0;
      head_id_q    <= '0;
      head_len_q   <= '0;
      beat_cnt_q   <= '0;
      cur_valid_q  <= 1'b0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_n;
      rd_ptr_q     <= rd_ptr_n;
      wr_ptr_q     <= wr_ptr_n;
      occ_q        <= occ_n;
      head_id_q    <= head_id_n;
      head_len_q   <= head_len_n;
      beat_cnt_q   <= beat_cnt_n;
      cur_valid_q  <= (state_n == ACTIVE);
      done_valid_q <= done_valid_n;
      done_id_q    <= done_id_n;
      err_q        <= zero_drop;
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_id[wr_ptr_q]  <= bus.meta_id_i;
      mem_len[wr_ptr_q] <= bus.meta_len_i;
    end
  end

  assign bus.meta_ready_o   = meta_ready;
  assign bus.write_ready_o  = write_ready;
  assign bus.cur_valid_o    = cur_valid_q;
  assign bus.cur_dma_id_o   = head_id_q;
  assign bus.beat_cnt_o     = beat_cnt_q;
  assign bus.done_valid_o   = done_valid_q;
  assign bus.done_id_o      = done_id_q;
  assign bus.occupancy_o    = occ_q;
  assign bus.err_zero_len_o = err_q;

endmodule

// File: tb/tb_xdma_meta_manager_mq.sv
// Bench for xdma_meta_manager_mq: directed scenarios with literal expectations
// followed by randomized traffic, all checked against a queue-based model.
module tb_xdma_meta_manager_mq;

  localparam int unsigned IdWidth  = 8;
  localparam int unsigned LenWidth = 16;
  localparam int unsigned Depth    = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  xdma_meta_manager_mq_if #(.IdWidth(IdWidth), .LenWidth(LenWidth), .Depth(Depth)) bus ();

  xdma_meta_manager_mq #(.IdWidth(IdWidth), .LenWidth(LenWidth), .Depth(Depth)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    int id;
    int len;
  } ent_t;

  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state.
  ent_t mq[$];
  int   m_cnt;
  bit   m_dv;
  int   m_did;
  bit   m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_cnt = 0;
    m_dv  = 1'b0;
    m_did = 0;
    m_err = 1'b0;
  endtask

  task automatic set_in(input bit mv, input int id, input int len,
                        input bit wh, input bit dr, input bit fl);
    bus.meta_valid_i      = mv;
    bus.meta_id_i         = IdWidth'(id);
    bus.meta_len_i        = LenWidth'(len);
    bus.write_happening_i = wh;
    bus.done_ready_i      = dr;
    bus.flush_i           = fl;
  endtask

  // Combinational readiness, compared after inputs settle.
  task automatic settle();
    bit exp_mr;
    bit exp_wr;
    #1;
    exp_mr = (mq.size() < Depth) && !bus.flush_i;
    exp_wr = (mq.size() > 0) && !(m_dv && !bus.done_ready_i);
    chk("meta_ready", 32'(bus.meta_ready_o), 32'(exp_mr));
    chk("write_ready", 32'(bus.write_ready_o), 32'(exp_wr));
  endtask

  task automatic cmp_model();
    chk("occupancy", 32'(bus.occupancy_o), 32'(mq.size()));
    chk("cur_valid", 32'(bus.cur_valid_o), 32'(mq.size() > 0));
    chk("cur_id", 32'(bus.cur_dma_id_o), (mq.size() > 0) ? 32'(mq[0].id) : 32'd0);
    chk("beat_cnt", 32'(bus.beat_cnt_o), 32'(m_cnt));
    chk("done_valid", 32'(bus.done_valid_o), 32'(m_dv));
    chk("done_id", 32'(bus.done_id_o), 32'(m_did));
    chk("err_zero_len", 32'(bus.err_zero_len_o), 32'(m_err));
  endtask

  // Advance the model by the rules, then one clock, then compare.
  task automatic tick();
    bit   fl;
    bit   acc;
    bit   wr;
    bit   beat;
    bit   pop;
    int   len;
    ent_t e;
    fl   = bus.flush_i;
    len  = int'(bus.meta_len_i);
    acc  = bus.meta_valid_i && (mq.size() < Depth) && !fl;
    wr   = (mq.size() > 0) && !(m_dv && !bus.done_ready_i);
    beat = bus.write_happening_i && wr && !fl;
    pop  = 1'b0;
    if (beat) pop = (m_cnt + 1 == mq[0].len);
    m_err = acc && (len == 0);
    if (pop) begin
      m_dv  = 1'b1;
      m_did = mq[0].id;
    end else if (m_dv && bus.done_ready_i) begin
      m_dv = 1'b0;
    end
    if (fl) begin
      mq.delete();
      m_cnt = 0;
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        m_cnt = 0;
      end else if (beat) begin
        m_cnt++;
      end
      if (acc && len != 0) begin
        e.id  = int'(bus.meta_id_i);
        e.len = len;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cmp_model();
    @(negedge clk);
  endtask

  task automatic cyc(input bit mv, input int id, input int len,
                     input bit wh, input bit dr, input bit fl);
    set_in(mv, id, len, wh, dr, fl);
    settle();
    tick();
  endtask

  // Reset asserted away from any clock edge; outputs must clear at once.
  task automatic reset_mid();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_occ", 32'(bus.occupancy_o), 32'd0);
    chk("rst_cur_valid", 32'(bus.cur_valid_o), 32'd0);
    chk("rst_cur_id", 32'(bus.cur_dma_id_o), 32'd0);
    chk("rst_beat_cnt", 32'(bus.beat_cnt_o), 32'd0);
    chk("rst_done_valid", 32'(bus.done_valid_o), 32'd0);
    chk("rst_done_id", 32'(bus.done_id_o), 32'd0);
    chk("rst_err", 32'(bus.err_zero_len_o), 32'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset_mid();
    #1;
    chk("ready_after_reset", 32'(bus.meta_ready_o), 32'd1);

    // Single-beat request completes the cycle after its beat.
    cyc(1, 88, 1, 0, 1, 0);
    chk("a_cur_valid", 32'(bus.cur_valid_o), 32'd1);
    chk("a_cur_id", 32'(bus.cur_dma_id_o), 32'd88);
    cyc(0, 0, 0, 1, 0, 0);
    chk("a_done_valid", 32'(bus.done_valid_o), 32'd1);
    chk("a_done_id", 32'(bus.done_id_o), 32'd88);
    chk("a_occ", 32'(bus.occupancy_o), 32'd0);
    chk("a_beat_cnt", 32'(bus.beat_cnt_o), 32'd0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("a_done_clear", 32'(bus.done_valid_o), 32'd0);

    // Fill to Depth, then drain in order.
    for (int k = 1; k <= 4; k++) cyc(1, k, 3, 0, 1, 0);
    chk("b_occ_full", 32'(bus.occupancy_o), 32'd4);
    for (int b = 1; b <= 12; b++) begin
      set_in(0, 0, 0, 1, 1, 0);
      settle();
      if (b == 1) chk("b_full_ready", 32'(bus.meta_ready_o), 32'd0);
      tick();
      if (b % 3 == 0) begin
        chk("b_done_valid", 32'(bus.done_valid_o), 32'd1);
        chk("b_done_id", 32'(bus.done_id_o), 32'(b / 3));
      end
    end
    chk("b_occ_empty", 32'(bus.occupancy_o), 32'd0);
    cyc(0, 0, 0, 0, 1, 0);

    // Unaccepted completion stalls counting for the next head.
    cyc(1, 5, 1, 0, 0, 0);
    cyc(1, 6, 2, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("c_done_id", 32'(bus.done_id_o), 32'd5);
    chk("c_cur_id", 32'(bus.cur_dma_id_o), 32'd6);
    for (int k = 0; k < 3; k++) begin
      set_in(0, 0, 0, 1, 0, 0);
      settle();
      chk("c_write_ready_blocked", 32'(bus.write_ready_o), 32'd0);
      tick();
      chk("c_beat_hold", 32'(bus.beat_cnt_o), 32'd0);
    end
    cyc(0, 0, 0, 1, 1, 0);
    chk("c_beat_resume", 32'(bus.beat_cnt_o), 32'd1);
    chk("c_done_taken", 32'(bus.done_valid_o), 32'd0);
    cyc(0, 0, 0, 1, 1, 0);
    chk("c_done6", 32'(bus.done_id_o), 32'd6);
    cyc(0, 0, 0, 0, 1, 0);

    // Zero-length request dropped with a one-cycle error pulse.
    cyc(1, 9, 0, 0, 1, 0);
    chk("d_err", 32'(bus.err_zero_len_o), 32'd1);
    chk("d_occ", 32'(bus.occupancy_o), 32'd0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("d_err_pulse", 32'(bus.err_zero_len_o), 32'd0);
    chk("d_no_done", 32'(bus.done_valid_o), 32'd0);

    // Flush mid-request, then flush with a completion pending.
    cyc(1, 21, 5, 0, 1, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 1, 0);
    chk("e_beat2", 32'(bus.beat_cnt_o), 32'd2);
    cyc(0, 0, 0, 1, 1, 1);
    chk("e_occ", 32'(bus.occupancy_o), 32'd0);
    chk("e_cur_valid", 32'(bus.cur_valid_o), 32'd0);
    chk("e_beat0", 32'(bus.beat_cnt_o), 32'd0);
    cyc(1, 22, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 23, 2, 1, 0, 1);
    chk("e_done_kept", 32'(bus.done_valid_o), 32'd1);
    chk("e_done_id", 32'(bus.done_id_o), 32'd22);
    chk("e_occ2", 32'(bus.occupancy_o), 32'd0);
    cyc(0, 0, 0, 0, 1, 0);

    // Reset with entries queued: nothing completes afterwards.
    cyc(1, 31, 2, 0, 1, 0);
    cyc(1, 32, 2, 0, 1, 0);
    cyc(1, 33, 2, 0, 1, 0);
    chk("f_occ3", 32'(bus.occupancy_o), 32'd3);
    reset_mid();
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 1, 1, 0);
    chk("f_no_done", 32'(bus.done_valid_o), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int len;
      len = ($urandom % 8 == 0) ? 0 : 1 + int'($urandom % 4);
      cyc(1'($urandom % 2), int'($urandom % 256), len,
          1'($urandom % 4 != 0), 1'($urandom % 3 != 0), 1'($urandom % 64 == 0));
      if (i % 700 == 699) reset_mid();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
